bnn_sequencer: RTL and testbench
================================

# bnn_sequencer

Top-level control stage of the MNIST BNN. Synchronises the two host input pins (start, serial pixel data) and drives the 3-bit `state` bus consumed by the pixel shift register and the layer blocks. Sequences IDLE → LOAD → L1 → L2 → L3 → DONE and latches the 4-bit classification. Also issues the per-frame clear that rearms the pixel register's sticky `load_done`.

## Interface
- `SYNC_STAGES`, default 2: flop stages in each pin synchroniser (≥2).
- `WDOG_CYCLES`, default 4096: per-layer timeout. Used only with the watchdog macro.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `start_pin` in 1: async host start level.
- `pixel_pin` in 1: async host serial pixel data, one bit per clk.
- `load_done` in 1: from pixel register, sticky high after 784 bits.
- `layer_done` in 1: level, high when the active layer (L1/L2/L3) has finished.
- `class_in` in 4: L3 classification, valid while `layer_done` is high in L3.
- `state` out 3: IDLE=000, LOAD=001, L1=010, L2=011, L3=100, DONE=101, ERR=110.
- `pixel_out` out 1: aligned pixel bit to the pixel register's data input.
- `frame_clr` out 1: active-high clear. Top level forms the register's `reset_n` as ~(reset | frame_clr).
- `busy` out 1: high in LOAD, L1, L2 and L3.
- `result_valid` out 1: high in DONE.
- `result` out 4: latched class.
- `error` out 1: high in ERR.

## Operation
- Each pin passes through a `SYNC_STAGES`-flop synchroniser, giving `start_s` and `data_s`.
- `start_q` is `start_s` delayed one cycle. `start_rise` = `start_s & ~start_q`.
- `pixel_out` is `data_s` delayed one further flop.
- Host protocol:
  - Host drives bit 0 on `pixel_pin` in the same cycle it raises `start_pin`.
  - Host then drives bits 1..783, one per cycle, in raster order.
  - Host holds `start_pin` high until `result_valid` or `error`.
  - Bits after 783 are ignored.
- IDLE:
  - On `start_rise`, go to LOAD.
  - `frame_clr` is combinational: (state ∈ {IDLE, DONE, ERR}) & `start_rise`.
- LOAD: stay until `load_done`=1, then go to L1.
- L1 → L2 → L3: each advances on `layer_done`=1.
- L3: on `layer_done`=1, set `result` ← `class_in` and go to DONE.
- DONE / ERR:
  - Hold all outputs.
  - A new `start_rise` asserts `frame_clr` and goes to LOAD, which is a restart.
  - `result` keeps its old value until overwritten in L3.
- `start_rise` in LOAD/L1/L2/L3 is ignored.
- A level-high `start_pin` held through reset does not retrigger. `start_rise` needs a low-to-high transition seen after reset.
- Unused encoding 111: next state IDLE.

## Timing
- Reset values:
  - `state`=000; `result`=0.
  - `result_valid`, `busy`, `error`, `frame_clr`, `pixel_out` all 0.
  - Synchroniser flops and `start_q` = 0.
- Pin-to-`start_rise` latency: `SYNC_STAGES` cycles.
- Let t be the cycle with `start_rise`=1:
  - `frame_clr`=1 in cycle t.
  - `state`=LOAD from t+1.
  - `pixel_out` at t+1+k equals host bit k.
- The pixel register shifts 784 times (t+1..t+784). `load_done` is visible at t+785, so `state`=L1 at t+786.
- Each layer transition occurs one cycle after `layer_done` is sampled high.
- `result` and `result_valid` update on the same edge as the L3→DONE transition.
- `reset` mid-frame returns to IDLE next edge and clears all outputs. The host must re-raise `start_pin`.

## Configuration
- `BNN_WATCHDOG_EN` defined:
  - 16-bit cycle counter, cleared on every state change, counting in L1/L2/L3.
  - If the counter reaches `WDOG_CYCLES`-1 without `layer_done`, next state is ERR and `error`=1.
  - A simultaneous `layer_done` wins over the timeout.
- `BNN_WATCHDOG_EN` undefined:
  - No counter; ERR is unreachable.
  - `error` is tied 0; `WDOG_CYCLES` is unused.

## Structure
- Shared package `bnn_pkg` holds:
  - The state typedef and its encodings (shared with the pixel register and layers).
  - `CLASS_W`=4.
  - `NUM_PIXELS`=784.
- One sub-module, `pin_sync`: parameterised N-stage flop synchroniser with synchronous active-high reset, instanced twice.

## Test plan
- Reset, then `start_pin` high with bits alternating 1,0,… for 784 cycles, `layer_done` tied 0 → `state`=001 for exactly 785 cycles after `frame_clr`. The downstream register holds pixels[0]=1, pixels[1]=0, pixels[783]=0.
- Full run with `layer_done` pulsed 1 cycle at 10 cycles into each layer and `class_in`=4'd7 → `state` steps 010, 011, 100, 101; `result`=7, `result_valid`=1, `busy`=0.
- `start_pin` toggled low then high during L2 → no `frame_clr`, no state change.
- From DONE, a second start with `class_in`=4'd3 → `frame_clr` pulses once. `result` stays 7 until L3→DONE, then becomes 3.
- `reset` asserted at cycle 400 of LOAD → next cycle `state`=000, all outputs 0. A new start completes a normal frame.
- `BNN_WATCHDOG_EN`, `WDOG_CYCLES`=16, `layer_done` never high in L1 → `state`=110, `error`=1 after 16 cycles in L1. A fresh start re-enters LOAD with `error`=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types for the MNIST BNN: state bus encoding, class width, frame size.
package bnn_pkg;

  localparam int CLASS_W    = 4;
  localparam int NUM_PIXELS = 784;
  localparam int STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_L1   = 3'b010,
    ST_L2   = 3'b011,
    ST_L3   = 3'b100,
    ST_DONE = 3'b101,
    ST_ERR  = 3'b110
  } state_e;

  function automatic logic is_layer(state_e s);
    return s inside {ST_L1, ST_L2, ST_L3};
  endfunction

  function automatic logic is_busy(state_e s);
    return s inside {ST_LOAD, ST_L1, ST_L2, ST_L3};
  endfunction

endpackage

// File: rtl/bnn_sequencer_if.sv
// Host pins, downstream handshakes and status outputs of the BNN sequencer.
interface bnn_sequencer_if;
  import bnn_pkg::*;

  logic               start_pin;
  logic               pixel_pin;
  logic               load_done;
  logic               layer_done;
  logic [CLASS_W-1:0] class_in;

  state_e             state;
  logic               pixel_out;
  logic               frame_clr;
  logic               busy;
  logic               result_valid;
  logic [CLASS_W-1:0] result;
  logic               error;

  modport master (
    output start_pin, pixel_pin, load_done, layer_done, class_in,
    input  state, pixel_out, frame_clr, busy, result_valid, result, error
  );

  modport slave (
    input  start_pin, pixel_pin, load_done, layer_done, class_in,
    output state, pixel_out, frame_clr, busy, result_valid, result, error
  );

endinterface

// File: rtl/bnn_sequencer_pin_sync.sv
// N-stage flop synchroniser for one asynchronous host pin, synchronous reset.
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bnn_sequencer.sv
// Frame sequencer IDLE->LOAD->L1->L2->L3->DONE with pin synchronisers.
// Define BNN_WATCHDOG_EN to add the per-layer timeout and the ERR state.
module bnn_sequencer
  import bnn_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           reset,
  bnn_sequencer_if.slave bus
);

  localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);

  generate
    if (SYNC_STAGES < 2 || WDOG_CYCLES < 2) begin : g_param_check
      $error("bnn_sequencer: SYNC_STAGES and WDOG_CYCLES must be >= 2");
    end
  endgenerate

  logic               start_s, data_s;
  logic               start_q, start_d;
  logic               pixel_q, pixel_d;
  logic               armed_q, armed_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  state_e             state_q, state_d;
  logic [CLASS_W-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               start_rise, frame_clr;

`ifdef BNN_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        error_q, error_d;
`endif

  pin_sync #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.start_pin),
    .q     (start_s)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.pixel_pin),
    .q     (data_s)
  );

  // A start level held through reset must not look like a fresh rising edge:
  // edges are accepted only after start_s has been seen low with the
  // synchroniser refilled from post-reset samples.
  always_comb begin
    start_d = start_s;
    pixel_d = data_s;
    fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    armed_d = armed_q | ((fill_q == FILL_FULL) & ~start_s);
  end

  assign start_rise = start_s & ~start_q & armed_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    result_d  = result_q;
    frame_clr = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_rise) begin
          frame_clr = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: if (bus.load_done)  state_d = ST_L1;
      ST_L1:   if (bus.layer_done) state_d = ST_L2;
      ST_L2:   if (bus.layer_done) state_d = ST_L3;
      ST_L3: begin
        if (bus.layer_done) begin
          result_d = bus.class_in;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef BNN_WATCHDOG_EN
    if (is_layer(state_q) && !bus.layer_done && wdog_q == WDOG_LIMIT) state_d = ST_ERR;
    wdog_d  = (state_d != state_q || !is_layer(state_q)) ? '0 : wdog_q + 16'd1;
    error_d = (state_d == ST_ERR);
`endif

    busy_d  = is_busy(state_d);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      start_q  <= 1'b0;
      pixel_q  <= 1'b0;
      armed_q  <= 1'b0;
      fill_q   <= '0;
      state_q  <= ST_IDLE;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef BNN_WATCHDOG_EN
      wdog_q   <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      start_q  <= start_d;
      pixel_q  <= pixel_d;
      armed_q  <= armed_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
`ifdef BNN_WATCHDOG_EN
      wdog_q   <= wdog_d;
      error_q  <= error_d;
`endif
    end
  end

  assign bus.state        = state_q;
  assign bus.pixel_out    = pixel_q;
  assign bus.frame_clr    = frame_clr;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
`ifdef BNN_WATCHDOG_EN
  assign bus.error        = error_q;
`else
  assign bus.error        = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_sequencer.sv
// Randomised frame-level bench for bnn_sequencer with a model of the pixel register.
module tb_bnn_sequencer;
  import bnn_pkg::*;

  localparam int S = 2;
  localparam int W = 16;
`ifdef BNN_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  bnn_sequencer_if bus ();

  bnn_sequencer #(.SYNC_STAGES(S), .WDOG_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_n  = 0;

  logic               host_bits [NUM_PIXELS];
  logic               pix_reg   [NUM_PIXELS];
  int                 pix_cnt = 0;
  bit                 ld_sched  [4096];
  state_e             exp_prev   = ST_IDLE;
  logic [CLASS_W-1:0] exp_result = '0;

  // Downstream pixel register: shifts while LOAD, sticky load_done after a full frame.
  always @(posedge clk) begin
    if (reset || bus.frame_clr) begin
      pix_cnt <= 0;
    end else if (bus.state == ST_LOAD && pix_cnt < NUM_PIXELS) begin
      pix_reg[pix_cnt] <= bus.pixel_out;
      pix_cnt          <= pix_cnt + 1;
    end
  end
  assign bus.load_done = (pix_cnt == NUM_PIXELS);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, cur_n, got, exp);
    end
  endtask

  task automatic check_outputs(input state_e st, input logic clr, input logic [CLASS_W-1:0] res);
    check("state",        32'(bus.state),        32'(st));
    check("frame_clr",    32'(bus.frame_clr),    32'(clr));
    check("busy",         32'(bus.busy),         32'(st inside {ST_LOAD, ST_L1, ST_L2, ST_L3}));
    check("result_valid", 32'(bus.result_valid), 32'(st == ST_DONE));
    check("error",        32'(bus.error),        32'(st == ST_ERR));
    check("result",       32'(bus.result),       32'(res));
  endtask

  // One host frame. d1..d3: cycles spent in each layer before it advances
  // (layer_done pulses in the last of them). n counts cycles from start_rise.
  task automatic run_frame(input int d1, input int d2, input int d3,
                           input logic [CLASS_W-1:0] cls, input bit toggle, input int abort_n);
    state_e             trace [$];
    state_e             layer_st [3];
    int                 d [3];
    state_e             term;
    state_e             st;
    logic [CLASS_W-1:0] res;
    int                 enter, dur, n, n_term, mism;
    int                 l2_enter = -100;
    int                 l3_n     = -100;
    bit                 aborted  = 1'b0;

    layer_st[0] = ST_L1; layer_st[1] = ST_L2; layer_st[2] = ST_L3;
    d[0] = d1; d[1] = d2; d[2] = d3;
    foreach (ld_sched[i]) ld_sched[i] = 1'b0;

    // 784 shifts plus the cycle in which load_done first becomes visible.
    for (int i = 0; i < NUM_PIXELS + 1; i++) trace.push_back(ST_LOAD);
    term = ST_DONE;
    for (int li = 0; li < 3; li++) begin
      enter = trace.size() + 1;
      if (li == 1) l2_enter = enter;
      dur = (WD && d[li] > W) ? W : d[li];
      for (int c = 0; c < dur; c++) trace.push_back(layer_st[li]);
      if (WD && d[li] > W) begin
        term = ST_ERR;
        break;
      end
      ld_sched[enter + d[li] - 1] = 1'b1;
      if (li == 2) l3_n = enter + d[li] - 1;
    end
    n_term = trace.size() + 1;

    for (int k = 0; k < n_term + S + 5; k++) begin
      @(negedge clk);
      n     = k - S;
      cur_n = n;
      st  = (n < 1) ? exp_prev : (n <= trace.size()) ? trace[n-1] : term;
      res = (term == ST_DONE && n >= n_term) ? cls : exp_result;
      check_outputs(st, n == 0, res);
      if (n >= 1 && n <= NUM_PIXELS) check("pixel_out", 32'(bus.pixel_out), 32'(host_bits[n-1]));

      if (k == 0) bus.start_pin = 1'b1;
      bus.pixel_pin  = (k < NUM_PIXELS) ? host_bits[k] : 1'($urandom);
      bus.layer_done = (n >= 1) ? ld_sched[n] : 1'b0;
      bus.class_in   = (n == l3_n) ? cls : 4'($urandom_range(0, 15));
      if (toggle && n == l2_enter + 2) bus.start_pin = 1'b0;
      if (toggle && n == l2_enter + 5) bus.start_pin = 1'b1;
      if (abort_n > 0 && n == abort_n) begin
        aborted = 1'b1;
        break;
      end
    end

    bus.layer_done = 1'b0;
    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      cur_n = -1;
      check_outputs(ST_IDLE, 1'b0, '0);
      check("pixel_out_rst", 32'(bus.pixel_out), 32'd0);
      reset = 1'b0;
      repeat (10) begin
        @(negedge clk);
        check_outputs(ST_IDLE, 1'b0, '0);
      end
      exp_prev   = ST_IDLE;
      exp_result = '0;
    end else begin
      mism = 0;
      for (int i = 0; i < NUM_PIXELS; i++) if (pix_reg[i] !== host_bits[i]) mism++;
      check("pixels", 32'(mism), 32'd0);
      exp_prev = term;
      if (term == ST_DONE) exp_result = cls;
    end
    bus.start_pin = 1'b0;
    repeat (5) begin
      @(negedge clk);
      cur_n = -1;
      check_outputs(exp_prev, 1'b0, exp_result);
    end
  endtask

  task automatic random_bits();
    for (int i = 0; i < NUM_PIXELS; i++) host_bits[i] = 1'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout n=%0d", cur_n);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset          = 1'b1;
    bus.start_pin  = 1'b0;
    bus.pixel_pin  = 1'b0;
    bus.layer_done = 1'b0;
    bus.class_in   = '0;
    repeat (3) @(negedge clk);
    cur_n = -1;
    check_outputs(ST_IDLE, 1'b0, '0);
    check("pixel_out_rst", 32'(bus.pixel_out), 32'd0);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_outputs(ST_IDLE, 1'b0, '0);
    end

    for (int i = 0; i < NUM_PIXELS; i++) host_bits[i] = (i % 2 == 0);
    run_frame(10, 10, 10, 4'd7, 1'b0, 0);
    check("pix0",   32'(pix_reg[0]),   32'd1);
    check("pix1",   32'(pix_reg[1]),   32'd0);
    check("pix783", 32'(pix_reg[783]), 32'd0);

    random_bits();
    run_frame(10, 14, 10, 4'd3, 1'b1, 0);

    random_bits();
    run_frame(10, 10, 10, 4'd5, 1'b0, 400);

    random_bits();
    run_frame(10, 10, 10, 4'd9, 1'b0, 0);

    random_bits();
    run_frame(W, 1, W, 4'd0, 1'b0, 0);

`ifdef BNN_WATCHDOG_EN
    random_bits();
    run_frame(100000, 5, 5, 4'd6, 1'b0, 0);
    random_bits();
    run_frame(3, 3, 3, 4'd12, 1'b0, 0);
`endif

    repeat (4) begin
      random_bits();
      run_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
                int'($urandom_range(1, 20)), 4'($urandom_range(0, 15)), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
